// File: rtl/button_conditioner_pkg.sv
// Shared constants for the push-button conditioner: 100 MHz timing defaults
// and the board channel assignment.
package button_conditioner_pkg;

    localparam int DEFAULT_N_CH            = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;   // 10 ms at 100 MHz
    localparam int DEFAULT_LONG_CYCLES     = 100000000; // 1 s at 100 MHz

    localparam int CH_START_F = 0;
    localparam int CH_START_T = 1;
    localparam int CH_STOP    = 2;
    localparam int CH_UPDATE  = 3;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned outputs, grouped as one bundle.
interface button_conditioner_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] din;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rising;
    logic [N_CH-1:0] falling;
    logic [N_CH-1:0] long_press;

    modport master (output din, input level, input rising, input falling, input long_press);
    modport slave  (input din, output level, output rising, output falling, output long_press);
endinterface

// File: rtl/button_conditioner_channel.sv
// One button channel: two-flop synchronizer, counter debouncer with edge
// pulses, and a saturating hold counter for the once-per-press long pulse.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rising,
    output logic falling,
    output logic long_press
);
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    logic              s1_r;
    logic              s2_r;
    logic [DB_W-1:0]   db_cnt_r;
    logic              level_r;
    logic              rising_r;
    logic              falling_r;
    logic [HOLD_W-1:0] hold_r;
    logic              long_r;

    // Synchronizer: only s2_r is seen by the debouncer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= din;
            s2_r <= s1_r;
        end
    end

    // Debounce: any return to the accepted level restarts the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_cnt_r  <= {DB_W{1'b0}};
            level_r   <= 1'b0;
            rising_r  <= 1'b0;
            falling_r <= 1'b0;
        end else begin
            rising_r  <= 1'b0;
            falling_r <= 1'b0;
            if (s2_r == level_r) begin
                db_cnt_r <= {DB_W{1'b0}};
            end else if (db_cnt_r == DB_LAST) begin
                db_cnt_r  <= {DB_W{1'b0}};
                level_r   <= s2_r;
                rising_r  <= s2_r;
                falling_r <= ~s2_r;
            end else begin
                db_cnt_r <= db_cnt_r + DB_W'(1);
            end
        end
    end

    // Hold counter saturates so long_press fires only on the PRE->MAX step.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_r <= {HOLD_W{1'b0}};
            long_r <= 1'b0;
        end else begin
            long_r <= level_r && (hold_r == HOLD_PRE);
            if (!level_r) begin
                hold_r <= {HOLD_W{1'b0}};
            end else if (hold_r != HOLD_MAX) begin
                hold_r <= hold_r + HOLD_W'(1);
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    assign level      = level_r;
    assign rising     = rising_r;
    assign falling    = falling_r;
    assign long_press = long_r;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner; every output comes straight from a
// per-channel register, so there is no combinational path from din.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_CH            = DEFAULT_N_CH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic                 clock,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);
    logic [N_CH-1:0] level_s;
    logic [N_CH-1:0] rising_s;
    logic [N_CH-1:0] falling_s;
    logic [N_CH-1:0] long_s;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .din        (bus.din[i]),
            .level      (level_s[i]),
            .rising     (rising_s[i]),
            .falling    (falling_s[i]),
            .long_press (long_s[i])
        );
    end

    assign bus.level      = level_s;
    assign bus.rising     = rising_s;
    assign bus.falling    = falling_s;
    assign bus.long_press = long_s;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    button_conditioner_if #(.N_CH(4)) bus ();

    button_conditioner #(
        .N_CH            (4),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.din = 4'b0000;
        reset   = 1'b0;
        tick(3);
        tests++;
        if ({bus.level, bus.rising, bus.falling, bus.long_press} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {bus.level, bus.rising, bus.falling, bus.long_press});
        end
        reset = 1'b1;
        tick(3);
        tests++;
        if ({bus.level, bus.rising, bus.falling, bus.long_press} !== 16'h0000) begin
            fails++;
            $display("FAIL idle_after_reset: got %h expected 0000",
                     {bus.level, bus.rising, bus.falling, bus.long_press});
        end
    endtask

    task automatic test_clean_press();
        bus.din = 4'b0001;
        tick(5);
        tests++;
        if (bus.level !== 4'b0000 || bus.rising !== 4'b0000) begin
            fails++;
            $display("FAIL press_edge5: level=%b rising=%b expected 0000/0000", bus.level, bus.rising);
        end
        tick(1);
        tests++;
        if (bus.level !== 4'b0001 || bus.rising !== 4'b0001 || bus.falling !== 4'b0000) begin
            fails++;
            $display("FAIL press_edge6: level=%b rising=%b falling=%b expected 0001/0001/0000",
                     bus.level, bus.rising, bus.falling);
        end
        tick(1);
        tests++;
        if (bus.level !== 4'b0001 || bus.rising !== 4'b0000) begin
            fails++;
            $display("FAIL press_edge7: level=%b rising=%b expected 0001/0000", bus.level, bus.rising);
        end
    endtask

    task automatic test_release();
        bus.din = 4'b0000;
        tick(5);
        tests++;
        if (bus.level !== 4'b0001 || bus.falling !== 4'b0000) begin
            fails++;
            $display("FAIL release_edge5: level=%b falling=%b expected 0001/0000", bus.level, bus.falling);
        end
        tick(1);
        tests++;
        if (bus.level !== 4'b0000 || bus.falling !== 4'b0001 || bus.rising !== 4'b0000) begin
            fails++;
            $display("FAIL release_edge6: level=%b falling=%b rising=%b expected 0000/0001/0000",
                     bus.level, bus.falling, bus.rising);
        end
        tick(1);
        tests++;
        if (bus.falling !== 4'b0000) begin
            fails++;
            $display("FAIL release_edge7: falling=%b expected 0000", bus.falling);
        end
        tick(4);
    endtask

    task automatic test_bounce();
        int early;
        early = 0;
        for (int k = 0; k < 12; k++) begin
            bus.din = {2'b00, ((k / 2) % 2 == 0), 1'b0};
            tick(1);
            if (bus.rising[1] !== 1'b0 || bus.level[1] !== 1'b0) early++;
        end
        bus.din = 4'b0010;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            if (bus.rising[1] !== 1'b0 || bus.level[1] !== 1'b0) early++;
        end
        tests++;
        if (early !== 0) begin
            fails++;
            $display("FAIL bounce_quiet: %0d cycles with activity, expected 0", early);
        end
        tick(1);
        tests++;
        if (bus.rising !== 4'b0010 || bus.level !== 4'b0010) begin
            fails++;
            $display("FAIL bounce_settle: rising=%b level=%b expected 0010/0010", bus.rising, bus.level);
        end
        tick(1);
        tests++;
        if (bus.rising !== 4'b0000) begin
            fails++;
            $display("FAIL bounce_single: rising=%b expected 0000", bus.rising);
        end
        bus.din = 4'b0000;
        tick(10);
    endtask

    task automatic test_long_press();
        int rise_cnt, rise_edge, long_cnt, long_edge, fall_cnt, fall_edge;
        rise_cnt = 0; rise_edge = 0; long_cnt = 0; long_edge = 0; fall_cnt = 0; fall_edge = 0;
        bus.din = 4'b0100;
        for (int e = 1; e <= 30; e++) begin
            tick(1);
            if (bus.rising[2] === 1'b1) begin rise_cnt++; rise_edge = e; end
            if (bus.long_press[2] === 1'b1) begin long_cnt++; long_edge = e; end
        end
        tests++;
        if (rise_cnt !== 1 || rise_edge !== 6) begin
            fails++;
            $display("FAIL long_rising: count=%0d edge=%0d expected 1 at 6", rise_cnt, rise_edge);
        end
        tests++;
        if (long_cnt !== 1 || long_edge !== 16) begin
            fails++;
            $display("FAIL long_pulse: count=%0d edge=%0d expected 1 at 16", long_cnt, long_edge);
        end
        tests++;
        if (bus.level !== 4'b0100) begin
            fails++;
            $display("FAIL long_level: level=%b expected 0100", bus.level);
        end
        bus.din = 4'b0000;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            if (bus.falling[2] === 1'b1) begin fall_cnt++; fall_edge = e; end
            if (bus.long_press[2] === 1'b1) long_cnt++;
        end
        tests++;
        if (fall_cnt !== 1 || fall_edge !== 6 || long_cnt !== 1 || bus.level !== 4'b0000) begin
            fails++;
            $display("FAIL long_release: falls=%0d edge=%0d longs=%0d level=%b expected 1/6/1/0000",
                     fall_cnt, fall_edge, long_cnt, bus.level);
        end
        tick(2);
    endtask

    task automatic test_reset_mid_count();
        int early;
        early = 0;
        bus.din = 4'b1000;
        tick(3);
        reset = 1'b0;
        #1;
        tests++;
        if ({bus.level, bus.rising, bus.falling, bus.long_press} !== 16'h0000) begin
            fails++;
            $display("FAIL midreset_assert: got %h expected 0000",
                     {bus.level, bus.rising, bus.falling, bus.long_press});
        end
        tick(2);
        tests++;
        if ({bus.level, bus.rising, bus.falling, bus.long_press} !== 16'h0000) begin
            fails++;
            $display("FAIL midreset_hold: got %h expected 0000",
                     {bus.level, bus.rising, bus.falling, bus.long_press});
        end
        reset = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            if (bus.rising !== 4'b0000 || bus.level !== 4'b0000) early++;
        end
        tests++;
        if (early !== 0) begin
            fails++;
            $display("FAIL midreset_early: %0d early cycles, expected 0", early);
        end
        tick(1);
        tests++;
        if (bus.rising !== 4'b1000 || bus.level !== 4'b1000) begin
            fails++;
            $display("FAIL midreset_rise: rising=%b level=%b expected 1000/1000", bus.rising, bus.level);
        end
        bus.din = 4'b0000;
        tick(10);
    endtask

    task automatic test_simultaneous();
        bus.din = 4'b1001;
        tick(5);
        tests++;
        if (bus.rising !== 4'b0000) begin
            fails++;
            $display("FAIL simul_early: rising=%b expected 0000", bus.rising);
        end
        tick(1);
        tests++;
        if (bus.rising !== 4'b1001 || bus.level !== 4'b1001) begin
            fails++;
            $display("FAIL simul_rise: rising=%b level=%b expected 1001/1001", bus.rising, bus.level);
        end
        bus.din = 4'b0000;
        tick(6);
        tests++;
        if (bus.falling !== 4'b1001 || bus.level !== 4'b0000) begin
            fails++;
            $display("FAIL simul_fall: falling=%b level=%b expected 1001/0000", bus.falling, bus.level);
        end
        tick(2);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b0;
        bus.din = 4'b0000;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_long_press();
        test_reset_mid_count();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Multi-channel front-end conditioner for the board push-buttons (start_f, start_t, stop_f_t, update) before they reach the control FSM in the system clock domain.
- Per channel: two-flop synchronizer, counter-based debouncer, one-cycle rising/falling pulses, and a once-per-press long-press pulse.
- Replaces bare edge detection so that contact bounce cannot create spurious state transitions.

Parameters:
- N_CH, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, cycles the synchronized input must hold a new value before it is accepted (10 ms at 100 MHz); must be >= 2.
- LONG_CYCLES, 100000000, cycles the debounced level must stay high before long_press fires (1 s at 100 MHz); must be > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock, single clock domain.
- reset  in  1  asynchronous reset, active-low: reset==0 clears all state immediately.
- din  in  N_CH  raw asynchronous button inputs, active-high.
- level  out  N_CH  debounced registered level per channel.
- rising  out  N_CH  one-cycle pulse when level goes 0->1.
- falling  out  N_CH  one-cycle pulse when level goes 1->0.
- long_press  out  N_CH  one-cycle pulse after level has been high for LONG_CYCLES cycles.

Behaviour:
- Reset (reset==0, asynchronous): sync flops, level, rising, falling, long_press, debounce counters and hold counters all 0.
- All outputs are registered; there is no combinational path from din to any output.
- Synchronizer: s1<=din, s2<=s1. s2 is the only signal the debouncer sees.
- Debounce counter, per channel, ceil(log2(DEBOUNCE_CYCLES)) bits:
  - s2==level: counter<=0.
  - s2!=level and counter<DEBOUNCE_CYCLES-1: counter<=counter+1.
  - s2!=level and counter==DEBOUNCE_CYCLES-1: level<=s2, counter<=0, and on the same edge rising<=s2 and falling<=~s2.
- Pulses: rising and falling default to 0 each cycle, so each pulse lasts exactly one cycle.
- Latency: for a clean din step held steady, level, rising and falling update on edge DEBOUNCE_CYCLES+2, counting the first edge that samples the new din as edge 1.
- Glitch rejection: if s2 returns to level before the count completes, the counter clears and no output changes. Bounce restarts the count from 0.
- Hold counter, per channel, ceil(log2(LONG_CYCLES+1)) bits:
  - level==0: hold counter<=0.
  - level==1: increments, saturating at LONG_CYCLES.
  - long_press<=1 for the single cycle in which the counter transitions LONG_CYCLES-1 -> LONG_CYCLES; at most once per press.
- Release: falling fires normally after a long press. The hold counter clears the cycle after level drops.
- Button held through reset release: level rises after the normal latency and rising fires once. This is required, not suppressed.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.
- Reset mid-count: all partial counts are discarded; no pulse is emitted on reset exit.

Decomposition:
- Shared package constants: default DEBOUNCE_CYCLES and LONG_CYCLES for 100 MHz, and channel index constants CH_START_F=0, CH_START_T=1, CH_STOP=2, CH_UPDATE=3.
- One natural sub-module: button_channel (synchronizer + debounce counter + hold counter for one bit). It is instantiated N_CH times in a generate loop; the top level only concatenates outputs.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, N_CH=4):
- Clean press, din[0] 0->1 held: level[0]=1 and rising[0]=1 on edge 6, rising[0]=0 on edge 7; other channels stay 0.
- Bounce, din[1] toggling high/low for 2 cycles each over 12 cycles, then held high: no rising[1] during bounce; rising[1] fires exactly once, 6 edges after the last 0->1 transition.
- Release, din[0] 1->0 after a stable press: falling[0]=1 for one cycle on edge 6, level[0]=0; no rising pulse.
- Long press, din[2] held high 30 cycles: rising[2] once, then long_press[2] exactly once 10 cycles after level[2] rises; no second long_press; falling[2] on release.
- Reset mid-count: din[3] high for 3 cycles, then reset=0 for 2 cycles with din[3] still high: all outputs 0 during reset; after release, rising[3] fires 6 edges later, not earlier.
- Simultaneous: din[0] and din[3] rise on the same edge: rising[0] and rising[3] both high on the same cycle.
